// File: rtl/ram_rw_responder_if.sv
// ram_rw_responder_if
//   Bundles the core request port (ram_rw_*) and the RAMHelper port
//   (ram_*) seen by ram_rw_responder.
//   Optional build macro RAM_RSP_MISALIGN_CHK_EN adds ram_rw_err_o.
//
//   Core side : ram_rw_cen_i, ram_rw_wen_i, ram_rw_addr_i, ram_rw_wdata_i,
//               ram_rw_size_i -> responder; ram_rw_ready_o, ram_rw_data_o
//               (and ram_rw_err_o) -> core.
//   RAM side  : ram_en_o, ram_wen_o, ram_idx_o, ram_wdata_o, ram_wmask_o
//               -> RAM; ram_rdata_i -> responder.
//
//   modport slave  : the responder's view.
//   modport master : the core/RAM environment's view.
interface ram_rw_responder_if;
    logic        ram_rw_cen_i;
    logic        ram_rw_wen_i;
    logic [63:0] ram_rw_addr_i;
    logic [63:0] ram_rw_wdata_i;
    logic [2:0]  ram_rw_size_i;
    logic        ram_rw_ready_o;
    logic [63:0] ram_rw_data_o;
`ifdef RAM_RSP_MISALIGN_CHK_EN
    logic        ram_rw_err_o;
`endif
    logic        ram_en_o;
    logic        ram_wen_o;
    logic [63:0] ram_idx_o;
    logic [63:0] ram_wdata_o;
    logic [63:0] ram_wmask_o;
    logic [63:0] ram_rdata_i;

    modport slave (
`ifdef RAM_RSP_MISALIGN_CHK_EN
        output ram_rw_err_o,
`endif
        input  ram_rw_cen_i, ram_rw_wen_i, ram_rw_addr_i, ram_rw_wdata_i,
               ram_rw_size_i, ram_rdata_i,
        output ram_rw_ready_o, ram_rw_data_o, ram_en_o, ram_wen_o,
               ram_idx_o, ram_wdata_o, ram_wmask_o
    );

    modport master (
`ifdef RAM_RSP_MISALIGN_CHK_EN
        input  ram_rw_err_o,
`endif
        output ram_rw_cen_i, ram_rw_wen_i, ram_rw_addr_i, ram_rw_wdata_i,
               ram_rw_size_i, ram_rdata_i,
        input  ram_rw_ready_o, ram_rw_data_o, ram_en_o, ram_wen_o,
               ram_idx_o, ram_wdata_o, ram_wmask_o
    );
endinterface

// File: rtl/ram_rw_responder.sv
// ram_rw_responder
//   Memory-side responder between the core's ram_rw_* port and a 64-bit
//   word RAM. Takes one request at a time, converts byte address/size into
//   a doubleword index plus bit write mask, aligns and extends load data,
//   and answers with a one-cycle ready pulse three cycles after acceptance.
//
//   Ports:
//     clock : rising-edge clock
//     reset : synchronous, active-high
//     bus   : ram_rw_responder_if.slave (core request port + RAM port)
//   Parameter:
//     PC_START : RAM base address; idx = (addr - PC_START) >> 3
//   Optional build macro:
//     RAM_RSP_MISALIGN_CHK_EN : misaligned requests skip the RAM access,
//                               return 0 and raise ram_rw_err_o in DONE.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | waiting for cen; latches the request when it arrives
//   S_ACCESS  | RAM enable/write cycle, index/mask/data driven
//   S_CAPTURE | RAM read data valid; formatted result stored in r_data
//   S_DONE    | ready pulse with r_data; always returns to S_IDLE
module ram_rw_responder #(
    parameter logic [63:0] PC_START = 64'h8000_0000
) (
    input  logic         clock,
    input  logic         reset,
    ram_rw_responder_if.slave bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACCESS  = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]  r_state;
    logic        r_wen;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [2:0]  r_size;
    logic [63:0] r_data;
`ifdef RAM_RSP_MISALIGN_CHK_EN
    logic        r_err;
`endif

    logic        w_access;
    logic        w_ram_go;
    logic        w_misalign;
    logic [2:0]  w_off;
    logic [7:0]  w_lanes;
    logic [7:0]  w_bmask;
    logic [63:0] w_bitmask;
    logic [63:0] w_shifted;
    logic [63:0] w_load;
    logic [63:0] w_rel_addr;

    assign w_access   = (r_state == S_ACCESS);
    assign w_off      = r_addr[2:0];
    assign w_rel_addr = r_addr - PC_START;

    always_comb begin
        w_lanes    = 8'h00;
        w_misalign = 1'b0;
        case (r_size[1:0])
            2'd0: begin w_lanes = 8'h01; w_misalign = 1'b0;        end
            2'd1: begin w_lanes = 8'h03; w_misalign = w_off[0];    end
            2'd2: begin w_lanes = 8'h0F; w_misalign = |w_off[1:0]; end
            default: begin w_lanes = 8'hFF; w_misalign = |w_off;   end
        endcase
        // Lanes shifted past byte 7 fall off the 8-bit mask.
        w_bmask = w_lanes << w_off;
        for (int i = 0; i < 8; i++) begin
            w_bitmask[8*i +: 8] = {8{w_bmask[i]}};
        end
    end

    always_comb begin
        w_shifted = bus.ram_rdata_i >> {w_off, 3'b000};
        case (r_size[1:0])
            2'd0:    w_load = {{56{~r_size[2] & w_shifted[7]}},  w_shifted[7:0]};
            2'd1:    w_load = {{48{~r_size[2] & w_shifted[15]}}, w_shifted[15:0]};
            2'd2:    w_load = {{32{~r_size[2] & w_shifted[31]}}, w_shifted[31:0]};
            default: w_load = w_shifted;
        endcase
    end

`ifdef RAM_RSP_MISALIGN_CHK_EN
    assign w_ram_go = w_access & ~w_misalign;
`else
    assign w_ram_go = w_access;
`endif

    // RAM-side outputs decode straight from the state register, so a write
    // in ACCESS still lands on the edge where reset is sampled.
    assign bus.ram_en_o       = w_ram_go;
    assign bus.ram_wen_o      = w_ram_go & r_wen;
    assign bus.ram_wmask_o    = w_ram_go ? w_bitmask : 64'd0;
    assign bus.ram_idx_o      = w_access ? {3'b000, w_rel_addr[63:3]} : 64'd0;
    assign bus.ram_wdata_o    = w_access ? (r_wdata << {w_off, 3'b000}) : 64'd0;
    assign bus.ram_rw_ready_o = (r_state == S_DONE);
    assign bus.ram_rw_data_o  = r_data;
`ifdef RAM_RSP_MISALIGN_CHK_EN
    assign bus.ram_rw_err_o   = r_err;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_wen   <= 1'b0;
            r_addr  <= 64'd0;
            r_wdata <= 64'd0;
            r_size  <= 3'd0;
            r_data  <= 64'd0;
`ifdef RAM_RSP_MISALIGN_CHK_EN
            r_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.ram_rw_cen_i) begin
                        r_wen   <= bus.ram_rw_wen_i;
                        r_addr  <= bus.ram_rw_addr_i;
                        r_wdata <= bus.ram_rw_wdata_i;
                        r_size  <= bus.ram_rw_size_i;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: r_state <= S_CAPTURE;
                S_CAPTURE: begin
`ifdef RAM_RSP_MISALIGN_CHK_EN
                    r_data  <= (r_wen | w_misalign) ? 64'd0 : w_load;
                    r_err   <= w_misalign;
`else
                    r_data  <= r_wen ? 64'd0 : w_load;
`endif
                    r_state <= S_DONE;
                end
                default: begin
`ifdef RAM_RSP_MISALIGN_CHK_EN
                    r_err   <= 1'b0;
`endif
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/ram_rw_responder.md
# ram_rw_responder

Memory-side responder for the core's `ram_rw_*` request port. It sits between the CPU core and the 64-bit-word RAMHelper model. It accepts one request at a time and translates byte address and size into a doubleword index plus byte write mask. For loads, it aligns and sign- or zero-extends the returned data, then answers with a single-cycle ready pulse. It replaces the fixed full-mask, always-ready glue in the simulation top.

## Interface
Parameters:
- `PC_START`, default 64'h8000_0000: RAM base address. RAM index is (addr − PC_START) >> 3.

Ports:
- `clock`  in  1  : single clock; all state updates on the rising edge.
- `reset`  in  1  : synchronous, active-high reset.
- `ram_rw_cen_i`  in  1  : request valid; held by the core until it sees ready.
- `ram_rw_wen_i`  in  1  : 1 = store, 0 = load.
- `ram_rw_addr_i`  in  64  : byte address.
- `ram_rw_wdata_i`  in  64  : store data, right-justified.
- `ram_rw_size_i`  in  3  : funct3 encoding.
  - [1:0] = log2(bytes): 0 = B, 1 = H, 2 = W, 3 = D.
  - [2] = 1 means unsigned load; ignored for stores.
- `ram_rw_ready_o`  out  1  : one-cycle completion pulse.
- `ram_rw_data_o`  out  64  : formatted load data; valid while ready is high.
- `ram_en_o`  out  1  : RAM enable.
- `ram_wen_o`  out  1  : RAM write enable.
- `ram_idx_o`  out  64  : doubleword index; drives both rIdx and wIdx.
- `ram_wdata_o`  out  64  : lane-shifted store data.
- `ram_wmask_o`  out  64  : bit-granular write mask.
- `ram_rdata_i`  in  64  : RAM read data; valid the cycle after `ram_en_o`.

## Operation
The block is a four-state FSM: IDLE → ACCESS → CAPTURE → DONE → IDLE.

IDLE:
- If `ram_rw_cen_i` = 1, latch wen, addr, wdata and size.
- Next state: ACCESS.
- Requests are only accepted in IDLE.

ACCESS:
- `ram_en_o` = 1.
- `ram_wen_o` = latched wen.
- `ram_idx_o` = (addr − PC_START) >> 3.
- Let off = addr[2:0] and n = 1 << size[1:0].
- `ram_wmask_o` = byte-lane mask of n bytes starting at lane off, expanded to bits.
  - Lanes above 7 are dropped.
- `ram_wdata_o` = wdata << (8·off).
- Next state: CAPTURE.

CAPTURE:
- Loads: data_q ← (ram_rdata_i >> 8·off), truncated to n bytes.
  - Sign-extend if size[2] = 0, zero-extend if size[2] = 1.
  - A D-size load is passed through unchanged.
- Stores: data_q ← 0.
- Next state: DONE.

DONE:
- `ram_rw_ready_o` = 1 and `ram_rw_data_o` = data_q.
- Next state: IDLE unconditionally.

General rules:
- In all states other than ACCESS, `ram_en_o`, `ram_wen_o` and `ram_wmask_o` are 0.
- `ram_rw_data_o` holds data_q at all times; it changes only in CAPTURE.
- `ram_rw_cen_i` is ignored in ACCESS, CAPTURE and DONE.
- If `ram_rw_cen_i` is still high in the IDLE cycle after DONE, a new transaction starts. The core must drop cen on the cycle it samples ready.
- Input changes after the latch cycle have no effect on the transaction in flight.

## Timing
- Request sampled in IDLE at cycle N:
  - `ram_en_o` high in N+1.
  - Data captured at the end of N+2.
  - `ram_rw_ready_o` high in N+3 only.
- Throughput: one transaction per 4 cycles (back-to-back cen).
- Reset values:
  - state = IDLE.
  - `ram_rw_ready_o` = 0, `ram_rw_data_o` = 0.
  - `ram_en_o` = 0, `ram_wen_o` = 0, `ram_wmask_o` = 0.
  - `ram_idx_o` = 0, `ram_wdata_o` = 0.
  - The latched request registers are 0.
- Reset asserted mid-transaction, in any state:
  - Next cycle is IDLE with all outputs at reset values.
  - No ready pulse and no RAM write after the reset edge.
  - A write in ACCESS coincident with reset still reaches the RAM that cycle; it is not cancelled.

## Configuration
- `RAM_RSP_MISALIGN_CHK_EN` defined:
  - Adds output `ram_rw_err_o` (1 bit), registered, reset value 0.
  - A request whose addr[2:0] is not a multiple of n skips the RAM access: `ram_en_o` stays 0 in ACCESS.
  - It completes on the normal N+3 schedule with data_q = 0.
  - `ram_rw_err_o` = 1 during that DONE cycle only.
- Not defined:
  - No err port.
  - Misaligned requests are performed with lanes truncated at the doubleword boundary.

## Test plan
- **Reset:** assert `reset` for 2 cycles with cen = 1 → all outputs 0 and no `ram_en_o` during reset; ready first rises 4 cycles after reset release.
- **Signed byte load:** RAM word at idx 0 = 64'h0123_4567_89AB_CDEF; load addr 0x8000_0002, size 3'b000 → `ram_idx_o` = 0 in N+1; ready in N+3 with data 64'hFFFF_FFFF_FFFF_FFAB.
- **Unsigned halfword load:** same word, addr 0x8000_0006, size 3'b101 → data 64'h0000_0000_0000_0123.
- **Word store:** addr 0x8000_0014, size 3'b010, wdata 64'hDEAD_BEEF → in N+1:
  - `ram_idx_o` = 2.
  - `ram_wmask_o` = 64'hFFFF_FFFF_0000_0000.
  - `ram_wdata_o` = 64'hDEAD_BEEF_0000_0000.
  - Ready in N+3; a subsequent D load of idx 2 shows the upper half updated and the lower half unchanged.
- **Back-to-back and timing:** cen held high across 3 loads → ready pulses at N+3, N+7, N+11; `ram_en_o` is high only at N+1, N+5, N+9.
- **Misaligned store:** D store at 0x8000_0004:
  - With `RAM_RSP_MISALIGN_CHK_EN`: no `ram_en_o`; `ram_rw_err_o` = 1 with ready in N+3.
  - Without: mask 64'hFFFF_FFFF_0000_0000, upper lanes written.
